// File: rtl/fetch_multi_if.sv
// fetch_multi_if: bundle of every signal between the fetch unit and its
// surroundings (instruction bus, branch predictor, fetch-to-decode FIFO,
// commit-stage redirect, performance counters).
//   master : the fetch unit (drives bus request, FIFO push, jump_wait, perf)
//   slave  : the environment (drives bus ack/data, prediction, FIFO space,
//            redirect)
// Parameters must match those of the fetch_multi instance it is bound to.
interface fetch_multi_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int FETCH_WIDTH = 4
);
    localparam int FREE_W = $clog2(FETCH_WIDTH) + 1;

    // instruction bus
    logic [ADDR_WIDTH-1:0]              bus_addr;
    logic                               bus_read_req;
    logic                               bus_read_ack;
    logic [INSTR_WIDTH*FETCH_WIDTH-1:0] bus_data;
    // branch prediction, valid alongside bus_read_ack
    logic [FETCH_WIDTH-1:0]             bp_taken;
    logic [ADDR_WIDTH-1:0]              bp_target;
    // fetch-to-decode FIFO
    logic [FREE_W-1:0]                  fifo_free;
    logic                               fifo_push;
    logic [FETCH_WIDTH-1:0]             fifo_valid;
    logic [INSTR_WIDTH*FETCH_WIDTH-1:0] fifo_instr;
    logic [ADDR_WIDTH*FETCH_WIDTH-1:0]  fifo_pc;
    logic [FETCH_WIDTH-1:0]             fifo_pred_taken;
    logic                               fifo_exc_misalign;
    // commit-stage redirect
    logic                               redirect_valid;
    logic [ADDR_WIDTH-1:0]              redirect_pc;
    // status and counters
    logic                               jump_wait;
    logic [31:0]                        perf_fetched;
    logic [31:0]                        perf_fifo_stall;

    modport master (
        output bus_addr, bus_read_req,
        input  bus_read_ack, bus_data,
        input  bp_taken, bp_target,
        input  fifo_free,
        output fifo_push, fifo_valid, fifo_instr, fifo_pc, fifo_pred_taken, fifo_exc_misalign,
        input  redirect_valid, redirect_pc,
        output jump_wait, perf_fetched, perf_fifo_stall
    );

    modport slave (
        input  bus_addr, bus_read_req,
        output bus_read_ack, bus_data,
        output bp_taken, bp_target,
        output fifo_free,
        input  fifo_push, fifo_valid, fifo_instr, fifo_pc, fifo_pred_taken, fifo_exc_misalign,
        output redirect_valid, redirect_pc,
        input  jump_wait, perf_fetched, perf_fifo_stall
    );
endinterface

// File: rtl/fetch_multi.sv
// fetch_multi: block-aligned instruction fetch unit, FETCH_WIDTH slots per
// block (power of two, 1..8).
//
// Fetches one aligned block per bus request, masks slots before the PC's
// start slot, truncates after the first predicted-taken slot or unpredicted
// jalr, and packs the surviving slots into the fetch-to-decode FIFO. A
// misaligned PC produces a single exception-tagged slot and parks the unit
// in JUMP_WAIT. Redirects from commit always win; a request already on the
// bus is drained (its data dropped) before a new one is issued.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   io   - fetch_multi_if.master: bus request/ack/data, branch prediction,
//          FIFO free count and push outputs, redirect, jump_wait, perf
//
// Optional build macro FETCH_PERF_COUNTER_EN: when defined, perf_fetched
// (slots pushed) and perf_fifo_stall (IDLE cycles starved of FIFO space)
// are live 32-bit wrapping counters; otherwise both read as 0.
module fetch_multi #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    FETCH_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h80000000
) (
    input logic           clk,
    input logic           rst,
    fetch_multi_if.master io
);
    localparam int LOG_FW   = $clog2(FETCH_WIDTH);
    localparam int OFS      = LOG_FW + 2;
    // wide enough to index 0 .. 2*FETCH_WIDTH-1 (start + output slot)
    localparam int IDX_W    = LOG_FW + 1;
    localparam int PC_BUS_W = ADDR_WIDTH * FETCH_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK  = ~ADDR_WIDTH'((64'd1 << OFS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);
    localparam logic [IDX_W-1:0]      FULL_FREE   = IDX_W'(FETCH_WIDTH);
    localparam logic [IDX_W-1:0]      LAST_SLOT   = IDX_W'(FETCH_WIDTH - 1);
    localparam logic [6:0]            OPC_JALR    = 7'b1100111;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN, JUMP_WAIT} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic                    req_reg, req_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;

    logic [ADDR_WIDTH-1:0]   base;
    logic [IDX_W-1:0]        start_idx;
    // slot views padded to 2*FETCH_WIDTH entries so start+j never leaves range
    logic [INSTR_WIDTH-1:0]  slot_instr [2*FETCH_WIDTH];
    logic [2*FETCH_WIDTH-1:0] slot_taken;
    logic [FETCH_WIDTH-1:0]  slot_stop;
    logic                    stop_found;
    logic [IDX_W-1:0]        stop_idx;
    logic [IDX_W-1:0]        last_idx;
    logic                    stop_is_taken;
    logic [IDX_W-1:0]        src_idx [FETCH_WIDTH];

    logic [FETCH_WIDTH-1:0]             pk_valid;
    logic [INSTR_WIDTH*FETCH_WIDTH-1:0] pk_instr;
    logic [PC_BUS_W-1:0]                pk_pc;
    logic [FETCH_WIDTH-1:0]             pk_taken;
    logic                               block_push;
    logic                               misalign_push;

    assign base = pc_reg & BLOCK_MASK;

    generate
        if (LOG_FW > 0) begin : g_start
            assign start_idx = {1'b0, pc_reg[OFS-1:2]};
        end else begin : g_start_one
            assign start_idx = '0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 2*FETCH_WIDTH; gi++) begin : g_slot
            if (gi < FETCH_WIDTH) begin : g_real
                assign slot_instr[gi] = io.bus_data[gi*INSTR_WIDTH +: INSTR_WIDTH];
                assign slot_taken[gi] = io.bp_taken[gi];
            end else begin : g_pad
                assign slot_instr[gi] = '0;
                assign slot_taken[gi] = 1'b0;
            end
        end

        // a slot ends the block if predicted taken or an unpredicted jalr
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_stop
            assign slot_stop[gi] = slot_taken[gi] | (slot_instr[gi][6:0] == OPC_JALR);
        end
    endgenerate

    // first stopping slot at or after the start slot
    always_comb begin
        stop_found = 1'b0;
        stop_idx   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!stop_found && (IDX_W'(i) >= start_idx) && slot_stop[i]) begin
                stop_found = 1'b1;
                stop_idx   = IDX_W'(i);
            end
        end
    end

    assign last_idx      = stop_found ? stop_idx : LAST_SLOT;
    assign stop_is_taken = slot_taken[stop_idx];

    // output slot j carries fetched slot start+j
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_pack
            assign src_idx[gi]  = start_idx + IDX_W'(gi);
            assign pk_valid[gi] = (src_idx[gi] <= last_idx);
            assign pk_instr[gi*INSTR_WIDTH +: INSTR_WIDTH] = slot_instr[src_idx[gi]];
            assign pk_taken[gi] = pk_valid[gi] & slot_taken[src_idx[gi]];
            assign pk_pc[gi*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'({src_idx[gi], 2'b00});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_next      = req_reg;
        addr_next     = addr_reg;
        block_push    = 1'b0;
        misalign_push = 1'b0;

        case (state_reg)
            IDLE: begin
                if (io.redirect_valid) begin
                    pc_next = io.redirect_pc;
                end else if (pc_reg[1:0] != 2'b00) begin
                    if (io.fifo_free != '0) begin
                        misalign_push = 1'b1;
                        state_next    = JUMP_WAIT;
                    end
                end else if (io.fifo_free == FULL_FREE) begin
                    // only request with room for a full block, so the ack
                    // cycle can always push
                    req_next   = 1'b1;
                    addr_next  = base;
                    state_next = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (io.redirect_valid) begin
                    pc_next = io.redirect_pc;
                    if (io.bus_read_ack) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (io.bus_read_ack) begin
                    req_next   = 1'b0;
                    block_push = 1'b1;
                    if (stop_found && stop_is_taken) begin
                        pc_next    = io.bp_target;
                        state_next = IDLE;
                    end else if (stop_found) begin
                        // unpredicted jalr: target unknown until commit redirects
                        state_next = JUMP_WAIT;
                    end else begin
                        pc_next    = base + BLOCK_BYTES;
                        state_next = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (io.redirect_valid) begin
                    pc_next = io.redirect_pc;
                end
                if (io.bus_read_ack) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end

            JUMP_WAIT: begin
                if (io.redirect_valid) begin
                    pc_next    = io.redirect_pc;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign io.bus_addr          = addr_reg;
    assign io.bus_read_req      = req_reg;
    assign io.fifo_push         = block_push | misalign_push;
    assign io.fifo_valid        = block_push ? pk_valid :
                                  (misalign_push ? FETCH_WIDTH'(1) : '0);
    assign io.fifo_instr        = block_push ? pk_instr : '0;
    assign io.fifo_pc           = block_push ? pk_pc :
                                  (misalign_push ? PC_BUS_W'(pc_reg) : '0);
    assign io.fifo_pred_taken   = block_push ? pk_taken : '0;
    assign io.fifo_exc_misalign = misalign_push;
    assign io.jump_wait         = (state_reg == JUMP_WAIT);

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] fetched_reg;
    logic [31:0] stall_reg;
    logic [FETCH_WIDTH-1:0] push_valid;

    assign push_valid = block_push ? pk_valid :
                        (misalign_push ? FETCH_WIDTH'(1) : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_reg <= '0;
            stall_reg   <= '0;
        end else begin
            if (block_push || misalign_push) begin
                fetched_reg <= fetched_reg + 32'($countones(push_valid));
            end
            if ((state_reg == IDLE) && (io.fifo_free < FULL_FREE) && !io.redirect_valid) begin
                stall_reg <= stall_reg + 32'd1;
            end
        end
    end

    assign io.perf_fetched    = fetched_reg;
    assign io.perf_fifo_stall = stall_reg;
`else
    assign io.perf_fetched    = '0;
    assign io.perf_fifo_stall = '0;
`endif

endmodule

// File: tb/tb_fetch_multi.sv
// tb_fetch_multi: directed bench for fetch_multi (FETCH_WIDTH = 4).
// Expected FIFO pushes are queued as stimulus is applied and checked by a
// negedge monitor when the DUT pushes; registered outputs are checked 1 ns
// after the rising edge.
module tb_fetch_multi;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int FW = 4;

    typedef struct packed {
        logic [3:0]   valid;
        logic [127:0] instr;
        logic [127:0] pc;
        logic [3:0]   pred;
        logic         exc;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_multi_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FETCH_WIDTH(FW)) io ();

    fetch_multi #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .FETCH_WIDTH(FW),
        .RESET_PC   (32'h80000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io.master)
    );

    int   n_vec = 0;
    int   n_err = 0;
    rec_t sb_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (io.bus_read_req === 1'b1) break;
            step();
        end
        chk(tag, io.bus_read_req, 1);
    endtask

    // four addi-like instructions; jalr_mask turns chosen slots into jalr
    function automatic logic [127:0] mk_data(input logic [7:0] seed, input logic [3:0] jalr_mask);
        logic [127:0] d;
        logic [31:0]  s;
        d = '0;
        for (int j = 0; j < FW; j++) begin
            s = {seed, 8'(j), 9'h0, 7'h13};
            if (jalr_mask[j]) s[6:0] = 7'h67;
            d[j*32 +: 32] = s;
        end
        return d;
    endfunction

    function automatic rec_t mk_rec(input logic [3:0] valid, input logic [31:0] pc0,
                                    input int slot0, input logic [3:0] pred,
                                    input logic exc, input logic [127:0] data);
        rec_t r;
        r       = '0;
        r.valid = valid;
        r.pred  = pred;
        r.exc   = exc;
        for (int j = 0; j < FW; j++) begin
            if (valid[j]) begin
                r.instr[j*32 +: 32] = data[(slot0 + j)*32 +: 32];
                r.pc[j*32 +: 32]    = pc0 + 32'(4 * j);
            end
        end
        return r;
    endfunction

    // scoreboard monitor; only slots marked valid are compared
    always @(negedge clk) begin : mon
        rec_t         e;
        logic [127:0] gi_m;
        logic [127:0] gp_m;
        if (rst === 1'b1 && io.fifo_push === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_push", io.fifo_push, 0);
            end else begin
                e    = sb_q.pop_front();
                gi_m = '0;
                gp_m = '0;
                for (int j = 0; j < FW; j++) begin
                    if (e.valid[j]) begin
                        gi_m[j*32 +: 32] = io.fifo_instr[j*32 +: 32];
                        gp_m[j*32 +: 32] = io.fifo_pc[j*32 +: 32];
                    end
                end
                chk("push_valid", io.fifo_valid, e.valid);
                chk("push_instr", gi_m, e.instr);
                chk("push_pc", gp_m, e.pc);
                chk("push_pred", io.fifo_pred_taken, e.pred);
                chk("push_exc", io.fifo_exc_misalign, e.exc);
                $display("push: valid=%b pc0=%h pred=%b exc=%b", io.fifo_valid,
                         io.fifo_pc[31:0], io.fifo_pred_taken, io.fifo_exc_misalign);
            end
        end
    end

    initial begin
        logic [127:0] d;
        logic [31:0]  s0;

        rst               = 1'b0;
        io.bus_read_ack   = 1'b0;
        io.bus_data       = '0;
        io.bp_taken       = '0;
        io.bp_target      = '0;
        io.fifo_free      = 3'd4;
        io.redirect_valid = 1'b0;
        io.redirect_pc    = '0;
        repeat (3) step();

        // reset state
        chk("rst_req", io.bus_read_req, 0);
        chk("rst_addr", io.bus_addr, 0);
        chk("rst_push", io.fifo_push, 0);
        chk("rst_jw", io.jump_wait, 0);
        chk("rst_perf_f", io.perf_fetched, 0);
        chk("rst_perf_s", io.perf_fifo_stall, 0);
        rst = 1'b1;
        wait_req("req0");
        chk("req0_addr", io.bus_addr, 32'h80000000);

        // aligned full block
        d = mk_data(8'h01, 4'b0000);
        sb_q.push_back(mk_rec(4'b1111, 32'h80000000, 0, 4'b0000, 1'b0, d));
        io.bus_data = d; io.bp_taken = 4'b0000; io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0;
        chk("post_ack_req", io.bus_read_req, 0);
        wait_req("req1");
        chk("seq_addr", io.bus_addr, 32'h80000010);

        // redirect while waiting: drain, old request held
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h80000018;
        step();
        io.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", io.bus_read_req, 1);
            chk("drain_addr", io.bus_addr, 32'h80000010);
            step();
        end
        io.bus_data = mk_data(8'h02, 4'b0000); io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0;
        wait_req("req_after_drain");
        chk("redir_base", io.bus_addr, 32'h80000010);
        $display("drain: new request addr=%h", io.bus_addr);

        // mid-block start, slot 3 predicted taken
        d = mk_data(8'h03, 4'b0000);
        sb_q.push_back(mk_rec(4'b0011, 32'h80000018, 2, 4'b0010, 1'b0, d));
        io.bus_data = d; io.bp_taken = 4'b1000; io.bp_target = 32'h80000100;
        io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0; io.bp_taken = 4'b0000;
        wait_req("req_target");
        chk("target_addr", io.bus_addr, 32'h80000100);

        // unpredicted jalr in slot 1
        d = mk_data(8'h04, 4'b0010);
        sb_q.push_back(mk_rec(4'b0011, 32'h80000100, 0, 4'b0000, 1'b0, d));
        io.bus_data = d; io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("jw_high", io.jump_wait, 1);
            chk("jw_noreq", io.bus_read_req, 0);
            step();
        end
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h80000200;
        step();
        io.redirect_valid = 1'b0;
        chk("jw_left", io.jump_wait, 0);
        wait_req("req_jw_redir");
        chk("jw_redir_addr", io.bus_addr, 32'h80000200);

        // redirect coincident with ack, to a misaligned pc
        sb_q.push_back(mk_rec(4'b0001, 32'h80000202, 0, 4'b0000, 1'b1, '0));
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h80000202;
        io.bus_data = mk_data(8'h05, 4'b0000); io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0; io.redirect_valid = 1'b0;
        step();
        chk("misalign_jw", io.jump_wait, 1);
        chk("misalign_noreq", io.bus_read_req, 0);

        // insufficient FIFO space in IDLE
        io.fifo_free = 3'd3;
        io.redirect_valid = 1'b1; io.redirect_pc = 32'hFFFFFFF0;
        step();
        io.redirect_valid = 1'b0;
        s0 = io.perf_fifo_stall;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_noreq", io.bus_read_req, 0);
        end
`ifdef FETCH_PERF_COUNTER_EN
        chk("perf_stall", io.perf_fifo_stall, s0 + 32'd4);
`else
        chk("perf_stall_off", io.perf_fifo_stall, 0);
`endif
        io.fifo_free = 3'd4;
        wait_req("req_wrap");
        chk("wrap_base", io.bus_addr, 32'hFFFFFFF0);

        // block at the top of the address space, next address wraps
        d = mk_data(8'h06, 4'b0000);
        sb_q.push_back(mk_rec(4'b1111, 32'hFFFFFFF0, 0, 4'b0000, 1'b0, d));
        io.bus_data = d; io.bus_read_ack = 1'b1;
        step();
        io.bus_read_ack = 1'b0;
        wait_req("req_wrapped");
        chk("wrap_addr", io.bus_addr, 32'h00000000);
`ifdef FETCH_PERF_COUNTER_EN
        chk("perf_fetched", io.perf_fetched, 32'd13);
`else
        chk("perf_fetched_off", io.perf_fetched, 0);
`endif

        // asynchronous reset mid-WAIT_ACK
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", io.bus_read_req, 0);
        chk("arst_addr", io.bus_addr, 0);
        chk("arst_jw", io.jump_wait, 0);
        chk("arst_push", io.fifo_push, 0);
        chk("arst_perf_f", io.perf_fetched, 0);
        chk("arst_perf_s", io.perf_fifo_stall, 0);
        step();
        step();
        rst = 1'b1;
        wait_req("req_after_arst");
        chk("arst_pc", io.bus_addr, 32'h80000000);

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
